// File: rtl/settle_checker.sv
// rtl/settle_checker.sv - settling monitor: band-hold detection with timeout and settle-time capture
module settle_checker #(
   parameter int WIDTH   = 25,
   parameter int HOLD    = 16,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] target,
   input  logic        [WIDTH-1:0] tol,
   input  logic signed [WIDTH-1:0] in,
   output logic                    busy,
   output logic                    done,
   output logic                    settled,
   output logic                    timeout,
   output logic        [CW-1:0]    settle_time,
   output logic        [WIDTH-1:0] max_err
);

   typedef enum logic {IDLE, TRACK} state_t;

   localparam logic [CW-1:0]    K_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]    HOLD_C    = CW'(HOLD);
   localparam logic [CW-1:0]    TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [CW-1:0]    ONE_C     = CW'(1);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  target_q, target_d;
   logic        [WIDTH-1:0]  tol_q, tol_d;
   logic        [CW-1:0]     k_q, k_d;
   logic        [CW-1:0]     run_q, run_d;
   logic        [CW-1:0]     run_start_q, run_start_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     settled_q, settled_d;
   logic                     timeout_q, timeout_d;
   logic        [CW-1:0]     settle_time_q, settle_time_d;
   logic        [WIDTH-1:0]  max_err_q, max_err_d;

   logic        [WIDTH:0]    err;
   logic        [WIDTH-1:0]  abs_err;
   logic                     in_band;
   logic        [CW-1:0]     run_inc;

   // Error magnitude: one extra bit makes the difference exact, and the
   // magnitude of a WIDTH+1-bit difference always fits in WIDTH unsigned bits.
   always_comb begin
      err     = {in[WIDTH-1], in} - {target_q[WIDTH-1], target_q};
      abs_err = err[WIDTH] ? (~err[WIDTH-1:0] + ONE_W) : err[WIDTH-1:0];
      in_band = (abs_err <= tol_q);
      run_inc = run_q + ONE_C;
   end

   // Next-state: start (re)arms from any state, otherwise TRACK takes one sample per edge.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      tol_d         = tol_q;
      k_d           = k_q;
      run_d         = run_q;
      run_start_d   = run_start_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      settled_d     = settled_q;
      timeout_d     = timeout_q;
      settle_time_d = settle_time_q;
      max_err_d     = max_err_q;

      if (start) begin
         target_d      = target;
         tol_d         = tol;
         k_d           = '0;
         run_d         = '0;
         run_start_d   = '0;
         busy_d        = 1'b1;
         settled_d     = 1'b0;
         timeout_d     = 1'b0;
         settle_time_d = '0;
         max_err_d     = '0;
         state_d       = TRACK;
      end else if (state_q == TRACK) begin
         if (abs_err > max_err_q) begin
            max_err_d = abs_err;
         end
         if (in_band) begin
            run_d = run_inc;
            if (run_q == '0) begin
               run_start_d = k_q;
            end
         end else begin
            run_d = '0;
         end

         // Settling on the last sample wins over the timeout.
         if (in_band && (run_inc == HOLD_C)) begin
            settled_d     = 1'b1;
            settle_time_d = (run_q == '0) ? k_q : run_start_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
         end else if (k_q == K_LAST) begin
            timeout_d     = 1'b1;
            settle_time_d = TIMEOUT_C;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
         end else begin
            k_d = k_q + ONE_C;
         end
      end
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         target_q      <= '0;
         tol_q         <= '0;
         k_q           <= '0;
         run_q         <= '0;
         run_start_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         settled_q     <= 1'b0;
         timeout_q     <= 1'b0;
         settle_time_q <= '0;
         max_err_q     <= '0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         tol_q         <= tol_d;
         k_q           <= k_d;
         run_q         <= run_d;
         run_start_q   <= run_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         settled_q     <= settled_d;
         timeout_q     <= timeout_d;
         settle_time_q <= settle_time_d;
         max_err_q     <= max_err_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign settled     = settled_q;
   assign timeout     = timeout_q;
   assign settle_time = settle_time_q;
   assign max_err     = max_err_q;

endmodule

// File: tb/tb_settle_checker.sv
// tb/tb_settle_checker.sv - randomized and directed bench for settle_checker against a window model
module tb_settle_checker;

   localparam int W  = 25;
   localparam int HD = 4;
   localparam int TO = 64;
   localparam int C  = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic signed [W-1:0] target;
   logic        [W-1:0] tol;
   logic signed [W-1:0] in;
   logic                busy, done, settled, timeout;
   logic        [C-1:0] settle_time;
   logic        [W-1:0] max_err;

   int checks = 0;
   int errors = 0;

   logic signed [W-1:0] samp [0:TO-1];
   longint              max_at [0:TO-1];

   settle_checker #(.WIDTH(W), .HOLD(HD), .TIMEOUT(TO), .CW(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .target(target), .tol(tol), .in(in),
      .busy(busy), .done(done), .settled(settled), .timeout(timeout),
      .settle_time(settle_time), .max_err(max_err)
   );

   always #5 clk = ~clk;

   // Model: the measurement ends at the first sample closing a window of HD
   // consecutive in-band samples, else at sample TO-1 as a timeout.
   task automatic model(input logic signed [W-1:0] tgt, input logic [W-1:0] tl,
                        output int e_end, output bit e_set, output int e_st);
      longint mx, d, a;
      bit ib [0:TO-1];
      bit found, all_in;
      mx = 0;
      for (int k = 0; k < TO; k++) begin
         d  = longint'(samp[k]) - longint'(tgt);
         a  = (d < 0) ? -d : d;
         ib[k] = (a <= longint'(tl));
         if (a > mx) mx = a;
         max_at[k] = mx;
      end
      found = 0; e_end = TO - 1; e_set = 0; e_st = TO;
      for (int k = HD - 1; k < TO; k++) begin
         if (!found) begin
            all_in = 1;
            for (int j = k - HD + 1; j <= k; j++) if (!ib[j]) all_in = 0;
            if (all_in) begin
               found = 1; e_end = k; e_set = 1; e_st = k - HD + 1;
            end
         end
      end
   endtask

   // Runs one measurement over samp[]; called and returns at a falling edge.
   task automatic measure(input logic signed [W-1:0] tgt, input logic [W-1:0] tl,
                          input bit chain, input string nm);
      int e_end, e_st;
      bit e_set;
      model(tgt, tl, e_end, e_set, e_st);
      start = 1'b1; target = tgt; tol = tl;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s armed: busy=%b done=%b required busy=1 done=0", nm, busy, done);
      end
      for (int k = 0; k <= e_end; k++) begin
         in = samp[k];
         @(negedge clk);
         checks++;
         if (done !== (k == e_end)) begin
            errors++;
            $display("FAIL %s done k=%0d: got %b required %b", nm, k, done, (k == e_end));
         end
         checks++;
         if (max_err !== W'(max_at[k])) begin
            errors++;
            $display("FAIL %s max_err k=%0d: got %0d required %0d", nm, k, max_err, max_at[k]);
         end
         if (k < e_end) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy k=%0d: got %b required 1", nm, k, busy);
            end
         end
      end
      checks++;
      if (busy !== 1'b0 || settled !== e_set || timeout !== !e_set || settle_time !== C'(e_st)) begin
         errors++;
         $display("FAIL %s result: busy=%b settled=%b timeout=%b settle_time=%0d required 0 %b %b %0d",
                  nm, busy, settled, timeout, settle_time, e_set, !e_set, e_st);
      end
      if (!chain) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || settled !== e_set || timeout !== !e_set || settle_time !== C'(e_st)) begin
            errors++;
            $display("FAIL %s hold: done=%b settled=%b timeout=%b settle_time=%0d required 0 %b %b %0d",
                     nm, done, settled, timeout, settle_time, e_set, !e_set, e_st);
         end
      end
   endtask

   task automatic check_all_zero(input string nm);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || settled !== 1'b0 || timeout !== 1'b0 ||
          settle_time !== '0 || max_err !== '0) begin
         errors++;
         $display("FAIL %s: busy=%b done=%b settled=%b timeout=%b settle_time=%0d max_err=%0d required all 0",
                  nm, busy, done, settled, timeout, settle_time, max_err);
      end
   endtask

   task automatic fill_const(input int v);
      for (int k = 0; k < TO; k++) samp[k] = W'(v);
   endtask

   task automatic fill_random(input int tgt, input int tl);
      int lim, mag;
      lim = $urandom_range(0, tl + 4);
      for (int k = 0; k < TO; k++) begin
         mag = (k < 6) ? $urandom_range(0, 40) : $urandom_range(0, lim);
         samp[k] = W'(($urandom_range(0, 1) != 0) ? tgt + mag : tgt - mag);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; target = '0; tol = '0; in = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("reset_released");
   endtask

   task automatic test_constant;
      fill_const(100);
      measure(W'(100), W'(0), 0, "constant");
      checks++;
      if (settle_time !== C'(0) || max_err !== W'(0)) begin
         errors++;
         $display("FAIL constant_values: settle_time=%0d max_err=%0d required 0 0", settle_time, max_err);
      end
   endtask

   task automatic test_step;
      int errs [0:3] = '{10, 6, 3, 1};
      fill_const(0);
      for (int k = 0; k < 4; k++) samp[k] = W'(errs[k]);
      measure(W'(0), W'(2), 0, "step");
      checks++;
      if (settle_time !== C'(3) || max_err !== W'(10)) begin
         errors++;
         $display("FAIL step_values: settle_time=%0d max_err=%0d required 3 10", settle_time, max_err);
      end
   endtask

   task automatic test_excursion;
      int errs [0:7] = '{0, 0, 0, 5, 2, 0, -2, 0};
      fill_const(0);
      for (int k = 0; k < 8; k++) samp[k] = W'(errs[k]);
      measure(W'(0), W'(2), 0, "excursion");
      checks++;
      if (settle_time !== C'(4) || settled !== 1'b1) begin
         errors++;
         $display("FAIL excursion_values: settle_time=%0d settled=%b required 4 1", settle_time, settled);
      end
   endtask

   task automatic test_never;
      fill_const(-7);
      measure(W'(-12), W'(2), 0, "never");
      checks++;
      if (timeout !== 1'b1 || settled !== 1'b0 || settle_time !== C'(TO) || max_err !== W'(5)) begin
         errors++;
         $display("FAIL never_values: timeout=%b settled=%b settle_time=%0d max_err=%0d required 1 0 %0d 5",
                  timeout, settled, settle_time, max_err, TO);
      end
   endtask

   task automatic test_extremes;
      logic [W-1:0] all_ones;
      all_ones = '1;
      fill_const(-(1 << (W - 1)));
      measure(W'((1 << (W - 1)) - 1), W'(0), 0, "extremes");
      checks++;
      if (max_err !== all_ones || timeout !== 1'b1) begin
         errors++;
         $display("FAIL extremes_values: max_err=%0h timeout=%b required %0h 1", max_err, timeout, all_ones);
      end
   endtask

   task automatic test_restart;
      start = 1'b1; target = W'(50); tol = W'(1);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in = W'(0);
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_prefix k=%0d: done=%b busy=%b required 0 1", k, done, busy);
         end
      end
      fill_random(-300, 3);
      measure(W'(-300), W'(3), 0, "restart");
   endtask

   task automatic test_reset_mid;
      start = 1'b1; target = W'(20); tol = W'(1);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in = W'(k * 9);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid");
      @(negedge clk);
      check_all_zero("reset_mid_held");
      rst_n = 1'b1;
      fill_random(77, 2);
      measure(W'(77), W'(2), 0, "after_reset");
   endtask

   task automatic test_back_to_back;
      fill_const(5);
      measure(W'(5), W'(0), 1, "b2b_first");
      fill_random(900, 4);
      measure(W'(900), W'(4), 0, "b2b_second");
   endtask

   task automatic test_random;
      int tgt, tl;
      for (int i = 0; i < 10; i++) begin
         tgt = $urandom_range(0, 2000) - 1000;
         tl  = $urandom_range(0, 6);
         fill_random(tgt, tl);
         measure(W'(tgt), W'(tl), ($urandom_range(0, 1) != 0), $sformatf("random%0d", i));
      end
   endtask

   initial begin
      test_reset;
      test_constant;
      test_step;
      test_excursion;
      test_never;
      test_extremes;
      test_restart;
      test_reset_mid;
      test_back_to_back;
      test_random;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
